// File: rtl/epcs_flash_resp_pkg.sv
// ---------------------------------------------------------------------------
// epcs_flash_resp_pkg
// Shared definitions for the EPCS serial-flash responder: opcode constants,
// the command FSM state encoding and the status-register bit positions.
// A small helper builds the status byte returned by RDSR.
// ---------------------------------------------------------------------------
package epcs_flash_resp_pkg;

    // Supported EPCS opcodes
    localparam logic [7:0] OP_WREN       = 8'h06;
    localparam logic [7:0] OP_WRDI       = 8'h04;
    localparam logic [7:0] OP_RDSR       = 8'h05;
    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_PROGRAM    = 8'h02;
    localparam logic [7:0] OP_BULK_ERASE = 8'hC7;

    // Status register bit positions
    localparam int SR_WIP_BIT = 0;
    localparam int SR_WEL_BIT = 1;

    // Command FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_READ_DATA,
        ST_PROG_DATA,
        ST_STATUS,
        ST_IGNORE
    } state_t;

    // Status byte as seen on MISO during RDSR
    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s             = 8'h00;
        s[SR_WEL_BIT] = wel;
        s[SR_WIP_BIT] = wip;
        return s;
    endfunction

endpackage

// File: rtl/epcs_flash_resp_mem.sv
// ---------------------------------------------------------------------------
// epcs_resp_mem
// Byte-wide single-port storage array for the flash responder.
// Reads are synchronous with one clock of latency; a write stores wdata at
// addr on the same edge. Contents are deliberately not reset.
//
// Ports
//   clk    system clock
//   addr   byte address (ADDR_W bits)
//   wdata  write data byte
//   we     write enable
//   rdata  registered read data (contents of addr one clock earlier)
// ---------------------------------------------------------------------------
module epcs_resp_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              we,
    output logic [7:0]        rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [0:DEPTH-1];

    // Read-first single port: rdata returns the old contents on a write cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/epcs_flash_resp.sv
// ---------------------------------------------------------------------------
// epcs_flash_resp
// Behavioural EPCS serial-flash responder. Decodes SPI mode-0 commands
// (WREN, WRDI, RDSR, READ, PROGRAM, BULK ERASE) from an EPCS initiator and
// serves them from an internal 2**ADDR_W byte array. SPI inputs are
// oversampled in the clk domain, so sck must run at clk/8 or slower.
//
// Ports
//   clk          system clock (single domain)
//   rst          asynchronous active-high reset
//   spi_ncs      chip select, active low
//   spi_sck      serial clock, mode 0
//   spi_mosi     serial data in, MSB first
//   spi_miso     serial data out, MSB first (0 when not driving)
//   spi_miso_oe  MISO drive enable
//   wel          write-enable latch
//   wip          write/erase in progress
//   cmd_err      one-cycle pulse on unsupported or rejected command
// ---------------------------------------------------------------------------
module epcs_flash_resp
    import epcs_flash_resp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int PROG_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_ncs,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic wel,
    output logic wip,
    output logic cmd_err
);

    localparam int CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

    // Synchronizers and edge detection
    logic [1:0] ncs_sync;
    logic [1:0] sck_sync;
    logic [1:0] mosi_sync;
    logic       ncs_s;
    logic       sck_s;
    logic       mosi_s;
    logic       ncs_q;
    logic       sck_q;
    logic       ncs_fall;
    logic       ncs_rise;
    logic       sck_rise;
    logic       sck_fall;

    // Serial receive
    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [7:0] byte_val;

    // FSM
    state_t     state;
    state_t     state_next;

    // Decode strobes
    logic       set_wel;
    logic       clr_wel;
    logic       start_erase;
    logic       err_evt;
    logic       prog_we;
    logic       read_load;

    // Command context and addressing
    logic              is_read;
    logic [1:0]        addr_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic              prog_written;

    // Busy tracking
    logic              erasing;
    logic [ADDR_W-1:0] erase_addr;
    logic [CNT_W-1:0]  prog_cnt;

    // Serial transmit
    logic [6:0] tx_shift;
    logic [2:0] out_cnt;
    logic       miso_q;
    logic [7:0] load_byte;

    // Memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    assign ncs_s  = ncs_sync[1];
    assign sck_s  = sck_sync[1];
    assign mosi_s = mosi_sync[1];

    // SCK edges only count while the chip is selected
    assign ncs_fall = ncs_q & ~ncs_s;
    assign ncs_rise = ~ncs_q & ncs_s;
    assign sck_rise = ~sck_q & sck_s & ~ncs_s;
    assign sck_fall = sck_q & ~sck_s & ~ncs_s;

    assign byte_val  = {rx_shift, mosi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);

    // Two-flop synchronizers plus one delay stage for edge detection.
    // ncs resets high so reset release never looks like a select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncs_sync  <= 2'b11;
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            ncs_q     <= 1'b1;
            sck_q     <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[0], spi_ncs};
            sck_sync  <= {sck_sync[0], spi_sck};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            ncs_q     <= ncs_s;
            sck_q     <= sck_s;
        end
    end

    // MOSI shift register and bit counter; either ncs edge drops a partial byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else if (ncs_fall || ncs_rise) begin
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else if (sck_rise) begin
            rx_shift <= byte_val[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        if (ncs_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_next = ST_OPCODE;
                    end
                end
                ST_OPCODE: begin
                    if (byte_done) begin
                        if (wip && byte_val != OP_RDSR) begin
                            state_next = ST_IGNORE;
                        end else begin
                            case (byte_val)
                                OP_RDSR:    state_next = ST_STATUS;
                                OP_READ:    state_next = ST_ADDR;
                                OP_PROGRAM: state_next = wel ? ST_ADDR : ST_IGNORE;
                                default:    state_next = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done && addr_cnt == 2'd2) begin
                        state_next = is_read ? ST_READ_DATA : ST_PROG_DATA;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // FSM outputs: opcode decode strobes, data-phase strobes and MISO enable
    always_comb begin
        set_wel     = 1'b0;
        clr_wel     = 1'b0;
        start_erase = 1'b0;
        err_evt     = 1'b0;
        if (state == ST_OPCODE && byte_done) begin
            if (wip && byte_val != OP_RDSR) begin
                err_evt = 1'b1;
            end else begin
                case (byte_val)
                    OP_WREN:       set_wel = 1'b1;
                    OP_WRDI:       clr_wel = 1'b1;
                    OP_RDSR:       err_evt = 1'b0;
                    OP_READ:       err_evt = 1'b0;
                    OP_PROGRAM:    err_evt = ~wel;
                    OP_BULK_ERASE: begin
                        start_erase = wel;
                        err_evt     = ~wel;
                    end
                    default:       err_evt = 1'b1;
                endcase
            end
        end
        prog_we     = (state == ST_PROG_DATA) && byte_done;
        read_load   = (state == ST_READ_DATA) && sck_fall && (out_cnt == 3'd0);
        spi_miso_oe = ((state == ST_READ_DATA) || (state == ST_STATUS)) && !ncs_s;
    end

    assign spi_miso = spi_miso_oe & miso_q;

    // Address collection and streaming pointer. Address bytes shift in from
    // the bottom so only the low ADDR_W bits of the 24-bit address survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_read      <= 1'b0;
            addr_cnt     <= '0;
            cur_addr     <= '0;
            prog_written <= 1'b0;
        end else begin
            if (ncs_fall) begin
                prog_written <= 1'b0;
            end
            if (state == ST_OPCODE && byte_done) begin
                is_read  <= (byte_val == OP_READ);
                addr_cnt <= '0;
                cur_addr <= '0;
            end
            if (state == ST_ADDR && byte_done) begin
                addr_cnt <= addr_cnt + 2'd1;
                cur_addr <= ADDR_W'({cur_addr, byte_val});
            end
            if (prog_we) begin
                cur_addr     <= cur_addr + ADDR_W'(1);
                prog_written <= 1'b1;
            end
            if (read_load) begin
                cur_addr <= cur_addr + ADDR_W'(1);
            end
        end
    end

    // Write-enable latch, program timer and bulk-erase sweep. A program
    // becomes busy only once ncs rises after at least one written byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wel        <= 1'b0;
            wip        <= 1'b0;
            erasing    <= 1'b0;
            erase_addr <= '0;
            prog_cnt   <= '0;
        end else begin
            if (set_wel) begin
                wel <= 1'b1;
            end
            if (clr_wel) begin
                wel <= 1'b0;
            end
            if (ncs_rise && prog_written) begin
                wip      <= 1'b1;
                wel      <= 1'b0;
                prog_cnt <= CNT_W'(PROG_CYCLES - 1);
            end else if (start_erase) begin
                wip        <= 1'b1;
                erasing    <= 1'b1;
                erase_addr <= '0;
            end else if (erasing) begin
                if (erase_addr == {ADDR_W{1'b1}}) begin
                    erasing <= 1'b0;
                    wip     <= 1'b0;
                    wel     <= 1'b0;
                end else begin
                    erase_addr <= erase_addr + ADDR_W'(1);
                end
            end else if (wip) begin
                if (prog_cnt == '0) begin
                    wip <= 1'b0;
                end else begin
                    prog_cnt <= prog_cnt - CNT_W'(1);
                end
            end
        end
    end

    // Error pulse is registered so it is exactly one clock wide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= err_evt;
        end
    end

    // A fresh byte is loaded at each byte boundary; status is sampled there
    assign load_byte = (state == ST_READ_DATA) ? mem_rdata : status_byte(wel, wip);

    // MISO shifter, advanced on sck falling edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
            out_cnt  <= '0;
            miso_q   <= 1'b0;
        end else if (state != ST_READ_DATA && state != ST_STATUS) begin
            tx_shift <= '0;
            out_cnt  <= '0;
            miso_q   <= 1'b0;
        end else if (sck_fall) begin
            if (out_cnt == 3'd0) begin
                miso_q   <= load_byte[7];
                tx_shift <= load_byte[6:0];
            end else begin
                miso_q   <= tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
            end
            out_cnt <= out_cnt + 3'd1;
        end
    end

    // Erase owns the port while active; otherwise the pointer addresses it so
    // rdata already holds the old byte when a program byte completes.
    always_comb begin
        mem_addr  = cur_addr;
        mem_we    = prog_we;
        mem_wdata = mem_rdata & byte_val;
        if (erasing) begin
            mem_addr  = erase_addr;
            mem_we    = 1'b1;
            mem_wdata = 8'hFF;
        end
    end

    epcs_resp_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .we    (mem_we),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_epcs_flash_resp.sv
// ---------------------------------------------------------------------------
// tb_epcs_flash_resp
// Self-checking bench for epcs_flash_resp. Drives EPCS command sequences over
// SPI mode 0 at clk/16 and compares against a byte-array model of the flash.
// ---------------------------------------------------------------------------
module tb_epcs_flash_resp;

    localparam int ADDR_W      = 8;
    localparam int PROG_CYCLES = 64;
    localparam int DEPTH       = 256;
    localparam int HALF        = 8;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic spi_ncs  = 1'b1;
    logic spi_sck  = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic spi_miso_oe;
    logic wel;
    logic wip;
    logic cmd_err;

    int checks     = 0;
    int failures   = 0;
    int err_cycles = 0;
    bit oe_seen;

    logic [7:0] model_mem [DEPTH];
    bit         model_wel;
    logic [7:0] pdata [8];
    logic [7:0] rgot  [8];

    epcs_flash_resp #(
        .ADDR_W      (ADDR_W),
        .PROG_CYCLES (PROG_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_ncs     (spi_ncs),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .wel         (wel),
        .wip         (wip),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    // Count every clock cmd_err is high, so a widened pulse shows up too
    always @(negedge clk) begin
        if (cmd_err) err_cycles++;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin();
        tick(6);
        oe_seen = 1'b0;
        spi_ncs = 1'b0;
        tick(HALF);
    endtask

    task automatic spi_end();
        tick(HALF);
        spi_ncs  = 1'b1;
        spi_mosi = 1'b0;
        tick(1);
    endtask

    // MISO is sampled as sck rises, mirroring the initiator's mode-0 capture
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            tick(HALF);
            spi_sck = 1'b1;
            rx = {rx[6:0], spi_miso};
            if (spi_miso_oe) oe_seen = 1'b1;
            tick(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cmd_simple(input logic [7:0] op);
        logic [7:0] rx;
        spi_begin();
        spi_byte(op, rx);
        spi_end();
        if (op == 8'h06 && !wip) model_wel = 1'b1;
        if (op == 8'h04 && !wip) model_wel = 1'b0;
    endtask

    task automatic cmd_status(input int n);
        logic [7:0] rx;
        spi_begin();
        spi_byte(8'h05, rx);
        for (int i = 0; i < n; i++) spi_byte(8'h00, rgot[i]);
        spi_end();
    endtask

    task automatic cmd_program(input logic [23:0] a, input int n);
        logic [7:0] rx;
        spi_begin();
        spi_byte(8'h02, rx);
        spi_byte(a[23:16], rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
        for (int i = 0; i < n; i++) spi_byte(pdata[i], rx);
        spi_end();
    endtask

    task automatic cmd_read(input logic [23:0] a, input int n);
        logic [7:0] rx;
        spi_begin();
        spi_byte(8'h03, rx);
        spi_byte(a[23:16], rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
        for (int i = 0; i < n; i++) spi_byte(8'h00, rgot[i]);
        spi_end();
    endtask

    // Flash semantics: programming can only clear bits, address wraps
    task automatic model_program(input logic [23:0] a, input int n);
        logic [7:0] idx;
        if (model_wel && n > 0) begin
            for (int i = 0; i < n; i++) begin
                idx = a[7:0] + 8'(i);
                model_mem[idx] = model_mem[idx] & pdata[i];
            end
            model_wel = 1'b0;
        end
    endtask

    task automatic model_erase();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hFF;
        model_wel = 1'b0;
    endtask

    task automatic wait_wip_rise(output bit to);
        int n = 0;
        while (!wip && n < 20) begin
            n++;
            tick(1);
        end
        to = !wip;
    endtask

    task automatic wait_wip_done(output int hi, output bit to);
        hi = 0;
        while (wip && hi < 5000) begin
            hi++;
            tick(1);
        end
        to = wip;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        checks++; if (wel !== 1'b0) begin failures++; $display("[TB] FAIL reset_wel: got %b expected 0", wel); end
        checks++; if (wip !== 1'b0) begin failures++; $display("[TB] FAIL reset_wip: got %b expected 0", wip); end
        checks++; if (cmd_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd_err: got %b expected 0", cmd_err); end
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("[TB] FAIL reset_miso: got %b expected 0", spi_miso); end
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_oe: got %b expected 0", spi_miso_oe); end
        rst = 1'b0;
        model_wel = 1'b0;
        tick(4);
        checks++; if (wel !== 1'b0 || wip !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_status: got wel=%b wip=%b expected 0 0", wel, wip); end
    endtask

    task automatic test_status();
        cmd_simple(8'h06);
        checks++; if (wel !== model_wel) begin failures++; $display("[TB] FAIL wren_wel: got %b expected %b", wel, model_wel); end
        cmd_status(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rgot[i] !== {6'b0, model_wel, 1'b0}) begin failures++; $display("[TB] FAIL rdsr_wren[%0d]: got %h expected %h", i, rgot[i], {6'b0, model_wel, 1'b0}); end
        end
        checks++; if (oe_seen !== 1'b1) begin failures++; $display("[TB] FAIL rdsr_oe: got %b expected 1", oe_seen); end
        cmd_simple(8'h04);
        checks++; if (wel !== model_wel) begin failures++; $display("[TB] FAIL wrdi_wel: got %b expected %b", wel, model_wel); end
        cmd_status(1);
        checks++; if (rgot[0] !== 8'h00) begin failures++; $display("[TB] FAIL rdsr_wrdi: got %h expected 00", rgot[0]); end
    endtask

    task automatic test_erase();
        int hi;
        bit to;
        logic [23:0] a;
        cmd_simple(8'h06);
        cmd_simple(8'hC7);
        checks++; if (wip !== 1'b1) begin failures++; $display("[TB] FAIL erase_wip_set: got %b expected 1", wip); end
        wait_wip_done(hi, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL erase_timeout: wip still %b after %0d cycles, required 0", wip, hi); end
        model_erase();
        checks++; if (wel !== model_wel) begin failures++; $display("[TB] FAIL erase_wel_clear: got %b expected %b", wel, model_wel); end
        for (int k = 0; k < 3; k++) begin
            a = {8'($urandom), 8'($urandom), 8'($urandom)};
            cmd_read(a, 2);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rgot[i] !== model_mem[a[7:0] + 8'(i)]) begin failures++; $display("[TB] FAIL erase_read[%0d]: got %h expected %h", i, rgot[i], model_mem[a[7:0] + 8'(i)]); end
            end
        end
    endtask

    task automatic test_program_read();
        int hi;
        bit to;
        cmd_simple(8'h06);
        pdata[0] = 8'hA5;
        pdata[1] = 8'h3C;
        cmd_program(24'h000010, 2);
        wait_wip_rise(to);
        checks++; if (to) begin failures++; $display("[TB] FAIL prog_wip_rise: got wip=%b expected 1", wip); end
        wait_wip_done(hi, to);
        checks++; if (hi !== PROG_CYCLES) begin failures++; $display("[TB] FAIL prog_wip_cycles: got %0d expected %0d", hi, PROG_CYCLES); end
        model_program(24'h000010, 2);
        checks++; if (wel !== model_wel) begin failures++; $display("[TB] FAIL prog_wel_clear: got %b expected %b", wel, model_wel); end
        cmd_read(24'h000010, 2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rgot[i] !== model_mem[8'h10 + 8'(i)]) begin failures++; $display("[TB] FAIL prog_read[%0d]: got %h expected %h", i, rgot[i], model_mem[8'h10 + 8'(i)]); end
        end
    endtask

    task automatic test_and();
        int hi;
        bit to;
        cmd_simple(8'h06);
        pdata[0] = 8'hA5;
        cmd_program(24'h000020, 1);
        wait_wip_done(hi, to);
        model_program(24'h000020, 1);
        cmd_simple(8'h06);
        pdata[0] = 8'h0F;
        cmd_program(24'h000020, 1);
        wait_wip_done(hi, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL and_timeout: wip %b after %0d cycles, required 0", wip, hi); end
        model_program(24'h000020, 1);
        cmd_read(24'h000020, 1);
        checks++; if (rgot[0] !== model_mem[8'h20]) begin failures++; $display("[TB] FAIL and_read: got %h expected %h", rgot[0], model_mem[8'h20]); end
    endtask

    task automatic test_wrap();
        int hi;
        bit to;
        logic [23:0] a;
        a = {8'($urandom), 8'($urandom), 8'hFF};
        for (int i = 0; i < 3; i++) pdata[i] = 8'($urandom);
        cmd_simple(8'h06);
        cmd_program(a, 3);
        wait_wip_done(hi, to);
        model_program(a, 3);
        cmd_read(24'h0000FF, 3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rgot[i] !== model_mem[8'hFF + 8'(i)]) begin failures++; $display("[TB] FAIL wrap_read[%0d]: got %h expected %h", i, rgot[i], model_mem[8'hFF + 8'(i)]); end
        end
    endtask

    task automatic test_errors();
        int e0;
        int hi;
        bit to;
        logic [7:0] rx;
        // Program without write enable
        e0 = err_cycles;
        pdata[0] = 8'h00;
        cmd_program(24'h000040, 1);
        tick(4);
        checks++; if (err_cycles - e0 !== 1) begin failures++; $display("[TB] FAIL noprog_err: got %0d err cycles expected 1", err_cycles - e0); end
        checks++; if (wip !== 1'b0) begin failures++; $display("[TB] FAIL noprog_wip: got %b expected 0", wip); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("[TB] FAIL noprog_oe: got %b expected 0", oe_seen); end
        // Unsupported opcode
        e0 = err_cycles;
        spi_begin();
        spi_byte(8'h9F, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_end();
        tick(4);
        checks++; if (err_cycles - e0 !== 1) begin failures++; $display("[TB] FAIL badop_err: got %0d err cycles expected 1", err_cycles - e0); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("[TB] FAIL badop_oe: got %b expected 0", oe_seen); end
        checks++; if (rx !== 8'h00) begin failures++; $display("[TB] FAIL badop_miso: got %h expected 00", rx); end
        // Bulk erase without write enable
        e0 = err_cycles;
        cmd_simple(8'hC7);
        tick(4);
        checks++; if (err_cycles - e0 !== 1 || wip !== 1'b0) begin failures++; $display("[TB] FAIL noerase: got err=%0d wip=%b expected 1 0", err_cycles - e0, wip); end
        cmd_read(24'h000040, 1);
        checks++; if (rgot[0] !== model_mem[8'h40]) begin failures++; $display("[TB] FAIL noprog_unchanged: got %h expected %h", rgot[0], model_mem[8'h40]); end
        // RDSR is still served while busy
        cmd_simple(8'h06);
        cmd_simple(8'hC7);
        cmd_status(1);
        checks++; if (rgot[0] !== 8'h03) begin failures++; $display("[TB] FAIL busy_rdsr: got %h expected 03", rgot[0]); end
        wait_wip_done(hi, to);
        model_erase();
        cmd_status(1);
        checks++; if (rgot[0] !== 8'h00) begin failures++; $display("[TB] FAIL idle_rdsr: got %h expected 00", rgot[0]); end
        // READ while busy is rejected
        cmd_simple(8'h06);
        cmd_simple(8'hC7);
        e0 = err_cycles;
        cmd_read(24'h000000, 1);
        checks++; if (err_cycles - e0 !== 1) begin failures++; $display("[TB] FAIL busy_read_err: got %0d err cycles expected 1", err_cycles - e0); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("[TB] FAIL busy_read_oe: got %b expected 0", oe_seen); end
        wait_wip_done(hi, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL busy_erase_timeout: wip %b after %0d cycles, required 0", wip, hi); end
        model_erase();
    endtask

    task automatic test_partial();
        logic [7:0] rx;
        cmd_simple(8'h06);
        spi_begin();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h60, rx);
        spi_bits(8'h00, 5, rx);
        spi_end();
        tick(20);
        checks++; if (wip !== 1'b0) begin failures++; $display("[TB] FAIL partial_wip: got %b expected 0", wip); end
        checks++; if (wel !== model_wel) begin failures++; $display("[TB] FAIL partial_wel: got %b expected %b", wel, model_wel); end
        cmd_status(1);
        checks++; if (rgot[0] !== {6'b0, model_wel, 1'b0}) begin failures++; $display("[TB] FAIL partial_rdsr: got %h expected %h", rgot[0], {6'b0, model_wel, 1'b0}); end
        cmd_read(24'h000060, 1);
        checks++; if (rgot[0] !== model_mem[8'h60]) begin failures++; $display("[TB] FAIL partial_read: got %h expected %h", rgot[0], model_mem[8'h60]); end
    endtask

    task automatic test_random();
        int hi;
        bit to;
        int n;
        logic [23:0] a;
        for (int k = 0; k < 6; k++) begin
            a = {8'($urandom), 8'($urandom), 8'($urandom)};
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) pdata[i] = 8'($urandom);
            cmd_simple(8'h06);
            cmd_program(a, n);
            wait_wip_done(hi, to);
            model_program(a, n);
            a[23:8] = 16'($urandom);
            cmd_read(a, n);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rgot[i] !== model_mem[a[7:0] + 8'(i)]) begin failures++; $display("[TB] FAIL random_read[%0d.%0d]: got %h expected %h", k, i, rgot[i], model_mem[a[7:0] + 8'(i)]); end
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_status();
        test_erase();
        test_program_read();
        test_and();
        test_wrap();
        test_errors();
        test_partial();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
